// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: runs one load/store as little-endian byte accesses on a byte-wide memory
// and returns the completion {valid, pc, res, rd, rob} on the result bus.
module lsu_mem_sequencer #(
    parameter int ADDR_WIDTH = 20,
    parameter int PREG_WIDTH = 6,
    parameter int ROB_WIDTH  = 6,
    parameter int PC_WIDTH   = 12,
    parameter int BUS_WIDTH  = 57
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [PREG_WIDTH-1:0] req_rd,
    input  logic [ROB_WIDTH-1:0]  req_rob,
    input  logic [PC_WIDTH-1:0]   req_pc,
    output logic                  mem_re,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic                  is_store, uns;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata, data, res;
    logic [PREG_WIDTH-1:0] rd, rd_res;
    logic [ROB_WIDTH-1:0]  rob;
    logic [PC_WIDTH-1:0]   pc;
    logic [2:0]            cnt, nbytes;
    logic [1:0]            lane;
    assign nbytes = (size == 2'd0) ? 3'd1 : (size == 2'd1) ? 3'd2 : 3'd4;
    // read data arrives one cycle late, so it belongs to the previous byte lane
    assign lane = cnt[1:0] - 2'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_store <= 1'b0;
            uns      <= 1'b0;
            size     <= '0;
            addr     <= '0;
            wdata    <= '0;
            data     <= '0;
            rd       <= '0;
            rob      <= '0;
            pc       <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                is_store <= req_is_store;
                uns      <= req_unsigned;
                size     <= req_size;
                addr     <= req_addr;
                wdata    <= req_wdata;
                rd       <= req_rd;
                rob      <= req_rob;
                pc       <= req_pc;
                cnt      <= '0;
                data     <= '0;
            end
            if (state == ACCESS) cnt <= cnt + 3'd1;
            if (!is_store && ((state == ACCESS && cnt != 3'd0) || state == WAIT))
                data[8*lane +: 8] <= mem_rdata;
        end
    end
    always_comb begin
        state_nx    = state;
        req_ready   = 1'b0;
        mem_re      = 1'b0;
        mem_wr      = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        busy        = 1'b1;
        bus_out     = '0;
        res         = '0;
        rd_res      = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                state_nx  = req_valid ? ACCESS : IDLE;
            end
            ACCESS: begin
                mem_address = addr + ADDR_WIDTH'(cnt);
                mem_wr      = is_store;
                mem_re      = !is_store;
                mem_wdata   = is_store ? wdata[8*cnt[1:0] +: 8] : 8'd0;
                state_nx    = (cnt != nbytes - 3'd1) ? ACCESS : is_store ? RESP : WAIT;
            end
            WAIT: state_nx = RESP;
            RESP: begin
                res = is_store ? 32'd0 :
                      (size == 2'd0) ? {{24{~uns & data[7]}}, data[7:0]} :
                      (size == 2'd1) ? {{16{~uns & data[15]}}, data[15:0]} : data;
                rd_res   = is_store ? '0 : rd;
                bus_out  = BUS_WIDTH'({1'b1, pc, res, rd_res, rob});
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
